mc_main_ctrl: RTL
=================

// Module: mc_main_ctrl
// PURPOSE
//  Main control FSM for the multicycle MIPS datapath; sits directly upstream of the ALU control unit.
//  Decodes opcode/func and sequences the fetch, decode, execute, memory and writeback steps.
//  Supplies the 4-bit ALUOp consumed by the ALU control unit:
//    0000 add, 0001 branch-sub, 0010 addiu, 0011 andi, 0100 lui, 0101 ori,
//    0110 slti, 0111 sltiu, 1000 xori, 1100 R-type.
//  Stalls on a mem_ready handshake and bounds every memory wait with a timeout.
// PARAMETERS
//  WAIT_MAX  15  max cycles a memory state waits for mem_ready before aborting
//  CNT_W     4   width of the wait counter; must satisfy 2**CNT_W > WAIT_MAX
// PORTS
//  clk          in   1  clock; all state updates on rising edge
//  rst_n        in   1  asynchronous active-low reset
//  opcode       in   6  IR[31:26]; valid from DECODE onward
//  func         in   6  IR[5:0]
//  mem_ready    in   1  memory completes the current access this cycle
//  PCWrite      out  1  unconditional PC load
//  PCWriteCond  out  1  PC load if branch condition true
//  BranchNE     out  1  1 = condition is !Zero (bne); 0 = Zero (beq)
//  IorD         out  1  memory address: 0 PC, 1 ALUOut
//  MemRead      out  1  memory read request
//  MemWrite     out  1  memory write request
//  IRWrite      out  1  load instruction register
//  MemtoReg     out  2  write data: 0 ALUOut, 1 MDR, 2 PC
//  RegDst       out  2  write register: 0 rt, 1 rd, 2 r31
//  RegWrite     out  1  register file write enable
//  ExtOp        out  1  immediate extension: 1 sign, 0 zero
//  ALUSrcB      out  2  ALU B operand: 0 B, 1 const 4, 2 ext(imm), 3 sext(imm)<<2
//  PCSource     out  2  PC source: 0 ALU result, 1 ALUOut, 2 jump target, 3 reg A
//  ALUOp        out  4  to ALU control unit (encoding in PURPOSE)
//  instr_done   out  1  1-cycle pulse in the final cycle of each instruction
//  illegal_op   out  1  1-cycle pulse: opcode/func not decodable
//  mem_err      out  1  1-cycle pulse: memory wait timed out
// BEHAVIOUR
//  Reset (async, rst_n=0):
//    state=RST, wait counter=0, every output 0.
//    RST -> FETCH on the first clock edge after rst_n is released.
//  Outputs are Moore (decoded from state only), except IRWrite, PCWrite, instr_done and mem_err,
//    which are qualified as listed below.
//  FETCH: MemRead, IorD=0, ALUSrcB=1, ALUOp=0000, PCSource=0.
//    IRWrite=PCWrite=mem_ready. Stay in FETCH until mem_ready=1, then go to DECODE.
//  DECODE: ALUSrcB=3, ALUOp=0000 (branch target into ALUOut). Next state by opcode:
//    lw/sw -> MEM_ADDR; R-type (000000) -> R_EXEC; beq/bne -> BRANCH; j/jal -> JUMP;
//    addiu/andi/lui/ori/slti/sltiu/xori -> I_EXEC.
//    Any other opcode: illegal_op=1 for one cycle, then FETCH.
//  MEM_ADDR: ALUSrcB=2, ExtOp=1, ALUOp=0000; lw -> MEM_RD, sw -> MEM_WR.
//  MEM_RD: MemRead, IorD=1. Wait for mem_ready, then MEM_WB.
//  MEM_WB: RegWrite, RegDst=0, MemtoReg=1, instr_done -> FETCH.
//  MEM_WR: MemWrite, IorD=1. On mem_ready: instr_done -> FETCH.
//  R_EXEC: ALUSrcB=0, ALUOp=1100.
//    func=001000 (jr) -> JR; else -> R_WB.
//  R_WB: RegWrite, RegDst=1, MemtoReg=0, ALUOp=1100, instr_done -> FETCH.
//  JR: PCWrite, PCSource=3, instr_done -> FETCH.
//  I_EXEC: ALUSrcB=2, ALUOp per opcode.
//    ExtOp=0 for andi/ori/xori; ExtOp=1 otherwise.
//    -> I_WB.
//  I_WB: same ALU controls as I_EXEC, plus RegWrite, RegDst=0, MemtoReg=0, instr_done -> FETCH.
//  BRANCH: ALUSrcB=0, ALUOp=0001, PCWriteCond, PCSource=1, BranchNE=(opcode==000101),
//    instr_done -> FETCH.
//  JUMP: PCWrite, PCSource=2, instr_done -> FETCH.
//    jal additionally: RegWrite, RegDst=2, MemtoReg=2 (PC already holds PC+4).
//  Latency in cycles, with zero-wait memory (mem_ready=1 on first request):
//    lw 5; sw 4; R-type 4; I-type 4; jr 4; beq/bne 3; j/jal 3.
//  Wait counter (applies in FETCH, MEM_RD, MEM_WR):
//    Cleared on entry to each of these states; increments every cycle mem_ready=0.
//    When mem_ready=0 and counter==WAIT_MAX: mem_err=1 for one cycle, state -> FETCH,
//      counter=0, no IRWrite/RegWrite/MemWrite asserted in that cycle.
//    mem_ready=1 on the same cycle counter hits WAIT_MAX: completion wins; mem_err stays 0.
//  Every instruction re-enters FETCH and waits there; a long mem_ready stall never skips states.
//  rst_n asserted in any state returns to RST immediately and drops all outputs that same cycle.
//  illegal_op and mem_err never assert in the same cycle.
// TESTING
//  1. Reset, release; mem_ready=1, opcode=000000, func=100001 ->
//     FETCH,DECODE,R_EXEC,R_WB; RegWrite=1 and RegDst=1 only in R_WB; ALUOp=1100; instr_done in cycle 4.
//  2. lw (100011) with mem_ready low 3 cycles in MEM_RD -> 8 cycles total;
//     MemRead held high with IorD=1 throughout the wait; MemtoReg=1 in MEM_WB.
//  3. bne (000101) -> 3 cycles; BRANCH cycle shows PCWriteCond=1, BranchNE=1, ALUOp=0001, PCSource=1.
//  4. jal (000011) -> JUMP cycle shows PCWrite=1, PCSource=2, RegWrite=1, RegDst=2, MemtoReg=2.
//  5. andi (001100) vs addiu (001001) -> ExtOp 0 vs 1; ALUOp 0011 vs 0010 in I_EXEC and I_WB.
//  6. Error and reset cases:
//     Opcode 111111 -> illegal_op pulse, then FETCH.
//     mem_ready held 0 in FETCH -> mem_err after 16 cycles (WAIT_MAX=15), no IRWrite.
//     rst_n pulsed low mid-MEM_WR -> all outputs 0 at once, restart from RST.

Source files
------------

// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and produces datapath controls plus the 4-bit ALUOp for the ALU control unit.
module mc_main_ctrl #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNE,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] MemtoReg,
  output logic [1:0] RegDst,
  output logic       RegWrite,
  output logic       ExtOp,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] ALUOp,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_err
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_R_EXEC, S_R_WB, S_JR, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wait_state;
  logic             timeout;
  logic [3:0]       imm_aluop;
  logic             imm_extop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Immediate-ALU decode shared by I_EXEC and I_WB; logical ops zero-extend.
  always_comb begin
    imm_aluop = 4'b0010;
    imm_extop = 1'b1;
    case (opcode)
      OP_ANDI:  begin imm_aluop = 4'b0011; imm_extop = 1'b0; end
      OP_LUI:   imm_aluop = 4'b0100;
      OP_ORI:   begin imm_aluop = 4'b0101; imm_extop = 1'b0; end
      OP_SLTI:  imm_aluop = 4'b0110;
      OP_SLTIU: imm_aluop = 4'b0111;
      OP_XORI:  begin imm_aluop = 4'b1000; imm_extop = 1'b0; end
      default:  imm_aluop = 4'b0010;
    endcase
  end

  assign wait_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign timeout    = wait_state && !mem_ready && (cnt_q == CNT_W'(WAIT_MAX));

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNE    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 2'd0;
    RegDst      = 2'd0;
    RegWrite    = 1'b0;
    ExtOp       = 1'b0;
    ALUSrcB     = 2'd0;
    PCSource    = 2'd0;
    ALUOp       = 4'b0000;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    mem_err     = 1'b0;

    // Counter runs only while a memory state is stalled; any exit or timeout clears it.
    if (wait_state && !mem_ready && !timeout) cnt_d = cnt_q + 1'b1;

    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'd1;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) state_d = S_DECODE;
        else if (timeout) begin
          mem_err = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'd3;
        case (opcode)
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_RTYPE:       state_d = S_R_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J, OP_JAL:   state_d = S_JUMP;
          OP_ADDIU, OP_ANDI, OP_LUI, OP_ORI, OP_SLTI, OP_SLTIU, OP_XORI:
                          state_d = S_I_EXEC;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcB = 2'd2;
        ExtOp   = 1'b1;
        state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
        else if (timeout) begin
          mem_err = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 2'd1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        // The write request is withdrawn in the cycle the wait is abandoned.
        MemWrite = !timeout;
        IorD     = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (timeout) begin
          mem_err = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_R_EXEC: begin
        ALUOp   = 4'b1100;
        state_d = (func == FN_JR) ? S_JR : S_R_WB;
      end
      S_R_WB: begin
        RegWrite   = 1'b1;
        RegDst     = 2'd1;
        ALUOp      = 4'b1100;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JR: begin
        PCWrite    = 1'b1;
        PCSource   = 2'd3;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_I_EXEC: begin
        ALUSrcB = 2'd2;
        ALUOp   = imm_aluop;
        ExtOp   = imm_extop;
        state_d = S_I_WB;
      end
      S_I_WB: begin
        ALUSrcB    = 2'd2;
        ALUOp      = imm_aluop;
        ExtOp      = imm_extop;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        ALUOp       = 4'b0001;
        PCWriteCond = 1'b1;
        PCSource    = 2'd1;
        BranchNE    = (opcode == OP_BNE);
        instr_done  = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'd2;
        // jal links PC (already PC+4) into r31.
        if (opcode == OP_JAL) begin
          RegWrite = 1'b1;
          RegDst   = 2'd2;
          MemtoReg = 2'd2;
        end
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_RST;
    endcase
  end

endmodule
